// File: rtl/encounter_sequencer.sv
// encounter_sequencer: overworld-to-battle handoff sequencer.
// Captures a pseudo-random wild species and runs the flash transition and the intro hold.
// Then runs the FIGHT/RUN menu, hands off to the battle engine and enforces a cooldown
// before the next encounter is accepted. All timing is in frameClk cycles.
// Optional build macro ENCOUNTER_SHINY_EN adds a shiny flag rolled from the LFSR.
module encounter_sequencer #(
    parameter int          FLASH_FRAMES    = 60,
    parameter int          FLASH_PERIOD    = 8,
    parameter int          INTRO_FRAMES    = 30,
    parameter int          COOLDOWN_FRAMES = 120,
    parameter int          NUM_SPECIES     = 6,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic       frameClk,
    input  logic       Reset,
    input  logic       fight_on,
    input  logic [7:0] keycode,
    input  logic       battle_done,
    output logic       overworld_lock,
    output logic       flash_on,
    output logic       battle_active,
    output logic       menu_sel,
    output logic       fight_req,
    output logic       run_escape,
    output logic [2:0] species,
    output logic       shiny,
    output logic [7:0] encounter_count
);

    generate
        if (FLASH_FRAMES < 1 || FLASH_FRAMES > 255 ||
            FLASH_PERIOD < 1 || FLASH_PERIOD > 255 ||
            INTRO_FRAMES < 1 || INTRO_FRAMES > 255 ||
            COOLDOWN_FRAMES < 1 || COOLDOWN_FRAMES > 255 ||
            NUM_SPECIES < 1 || NUM_SPECIES > 8 ||
            LFSR_SEED == 16'h0000) begin : g_param_check
            $error("encounter_sequencer: parameter out of range");
        end
    endgenerate

    localparam logic [7:0] FLASH_LAST    = 8'(FLASH_FRAMES - 1);
    localparam logic [7:0] INTRO_LAST    = 8'(INTRO_FRAMES - 1);
    localparam logic [7:0] COOLDOWN_LAST = 8'(COOLDOWN_FRAMES - 1);
    localparam logic [7:0] FLASH_PER_W   = 8'(FLASH_PERIOD);
    localparam logic [7:0] NUM_SPECIES_W = 8'(NUM_SPECIES);

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRANSITION,
        S_INTRO,
        S_MENU,
        S_BATTLE,
        S_COOLDOWN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        fight_on_q, fight_on_d;
    logic [7:0]  keycode_q, keycode_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        flash_on_q, flash_on_d;
    logic        menu_sel_q, menu_sel_d;
    logic        fight_req_q, fight_req_d;
    logic        run_escape_q, run_escape_d;
    logic [2:0]  species_q, species_d;
    logic [7:0]  encounter_count_q, encounter_count_d;

    logic        fight_rise;
    logic        enter_rise;
    logic        accept;
    logic [7:0]  cnt_inc;
    logic [2:0]  species_new;

    assign fight_rise  = fight_on & ~fight_on_q;
    assign enter_rise  = (keycode == KEY_ENTER) & (keycode_q != KEY_ENTER);
    assign accept      = (state_q == S_IDLE) & fight_rise;
    assign cnt_inc     = frame_cnt_q + 8'd1;
    // Species is taken from the pre-advance LFSR value in the accepting cycle.
    assign species_new = 3'(lfsr_q[7:0] % NUM_SPECIES_W);

    // Free-running LFSR and the input history used for edge detection
    always_comb begin
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        fight_on_d = fight_on;
        keycode_d  = keycode;
    end

    // Next-state and registered-output logic of the encounter sequence
    always_comb begin
        state_d           = state_q;
        frame_cnt_d       = frame_cnt_q;
        flash_on_d        = flash_on_q;
        menu_sel_d        = menu_sel_q;
        fight_req_d       = 1'b0;
        run_escape_d      = 1'b0;
        species_d         = species_q;
        encounter_count_d = encounter_count_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    species_d   = species_new;
                    if (encounter_count_q != 8'hFF) begin
                        encounter_count_d = encounter_count_q + 8'd1;
                    end
                    frame_cnt_d = 8'd0;
                    flash_on_d  = 1'b1;
                    state_d     = S_TRANSITION;
                end
            end
            S_TRANSITION: begin
                if (frame_cnt_q == FLASH_LAST) begin
                    flash_on_d  = 1'b0;
                    frame_cnt_d = 8'd0;
                    state_d     = S_INTRO;
                end else begin
                    frame_cnt_d = cnt_inc;
                    if ((cnt_inc % FLASH_PER_W) == 8'd0) begin
                        flash_on_d = ~flash_on_q;
                    end
                end
            end
            S_INTRO: begin
                if (frame_cnt_q == INTRO_LAST) begin
                    frame_cnt_d = 8'd0;
                    menu_sel_d  = 1'b0;
                    state_d     = S_MENU;
                end else begin
                    frame_cnt_d = cnt_inc;
                end
            end
            S_MENU: begin
                // Confirm acts on the cursor as it stood before this cycle.
                if (enter_rise) begin
                    frame_cnt_d = 8'd0;
                    if (!menu_sel_q) begin
                        fight_req_d = 1'b1;
                        state_d     = S_BATTLE;
                    end else begin
                        run_escape_d = 1'b1;
                        state_d      = S_COOLDOWN;
                    end
                end else if (keycode == KEY_W) begin
                    menu_sel_d = 1'b0;
                end else if (keycode == KEY_S) begin
                    menu_sel_d = 1'b1;
                end
            end
            S_BATTLE: begin
                if (battle_done) begin
                    frame_cnt_d = 8'd0;
                    state_d     = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if (frame_cnt_q == COOLDOWN_LAST) begin
                    frame_cnt_d = 8'd0;
                    state_d     = S_IDLE;
                end else begin
                    frame_cnt_d = cnt_inc;
                end
            end
            default: begin
                frame_cnt_d = 8'd0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge frameClk or negedge Reset) begin
        if (!Reset) begin
            state_q           <= S_IDLE;
            lfsr_q            <= LFSR_SEED;
            fight_on_q        <= 1'b0;
            keycode_q         <= 8'h00;
            frame_cnt_q       <= 8'd0;
            flash_on_q        <= 1'b0;
            menu_sel_q        <= 1'b0;
            fight_req_q       <= 1'b0;
            run_escape_q      <= 1'b0;
            species_q         <= 3'd0;
            encounter_count_q <= 8'd0;
        end else begin
            state_q           <= state_d;
            lfsr_q            <= lfsr_d;
            fight_on_q        <= fight_on_d;
            keycode_q         <= keycode_d;
            frame_cnt_q       <= frame_cnt_d;
            flash_on_q        <= flash_on_d;
            menu_sel_q        <= menu_sel_d;
            fight_req_q       <= fight_req_d;
            run_escape_q      <= run_escape_d;
            species_q         <= species_d;
            encounter_count_q <= encounter_count_d;
        end
    end

`ifdef ENCOUNTER_SHINY_EN
    logic shiny_q, shiny_d;

    // Roll the shiny flag in the same cycle the species is captured
    always_comb begin
        shiny_d = shiny_q;
        if (accept) begin
            shiny_d = (lfsr_q[11:8] == 4'h0);
        end
    end

    // Shiny flag register
    always_ff @(posedge frameClk or negedge Reset) begin
        if (!Reset) begin
            shiny_q <= 1'b0;
        end else begin
            shiny_q <= shiny_d;
        end
    end

    assign shiny = shiny_q;
`else
    assign shiny = 1'b0;
`endif

    // State-decoded outputs fall with the state register on an asynchronous reset.
    assign overworld_lock  = (state_q != S_IDLE);
    assign battle_active   = (state_q == S_INTRO) || (state_q == S_MENU) || (state_q == S_BATTLE);
    assign flash_on        = flash_on_q;
    assign menu_sel        = menu_sel_q;
    assign fight_req       = fight_req_q;
    assign run_escape      = run_escape_q;
    assign species         = species_q;
    assign encounter_count = encounter_count_q;

endmodule

// File: tb/tb_encounter_sequencer.sv
// Testbench for encounter_sequencer: directed scenarios followed by randomized stimulus.
// A phase/elapsed-time reference model predicts every output on every cycle.
module tb_encounter_sequencer;

    localparam int FLASH_FRAMES    = 60;
    localparam int FLASH_PERIOD    = 8;
    localparam int INTRO_FRAMES    = 30;
    localparam int COOLDOWN_FRAMES = 120;
    localparam int NUM_SP          = 6;

    localparam int P_IDLE   = 0;
    localparam int P_TRANS  = 1;
    localparam int P_INTRO  = 2;
    localparam int P_MENU   = 3;
    localparam int P_BATTLE = 4;
    localparam int P_COOL   = 5;

    logic       frameClk = 1'b0;
    logic       Reset = 1'b0;
    logic       fight_on = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       battle_done = 1'b0;
    logic       overworld_lock, flash_on, battle_active, menu_sel;
    logic       fight_req, run_escape, shiny;
    logic [2:0] species;
    logic [7:0] encounter_count;

    encounter_sequencer dut (
        .frameClk        (frameClk),
        .Reset           (Reset),
        .fight_on        (fight_on),
        .keycode         (keycode),
        .battle_done     (battle_done),
        .overworld_lock  (overworld_lock),
        .flash_on        (flash_on),
        .battle_active   (battle_active),
        .menu_sel        (menu_sel),
        .fight_req       (fight_req),
        .run_escape      (run_escape),
        .species         (species),
        .shiny           (shiny),
        .encounter_count (encounter_count)
    );

    always #5 frameClk = ~frameClk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase, cycles elapsed in phase, and the visible results.
    int          m_phase;
    int          m_t;
    logic [15:0] m_lfsr;
    int          m_count;
    int          m_accepted;
    logic [2:0]  m_species;
    logic        m_shiny;
    logic        m_sel;
    logic        m_fight_req;
    logic        m_run;
    logic        m_prev_fight;
    logic [7:0]  m_prev_key;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic model_reset();
        m_phase      = P_IDLE;
        m_t          = 0;
        m_lfsr       = 16'hACE1;
        m_count      = 0;
        m_species    = 3'd0;
        m_shiny      = 1'b0;
        m_sel        = 1'b0;
        m_fight_req  = 1'b0;
        m_run        = 1'b0;
        m_prev_fight = 1'b0;
        m_prev_key   = 8'h00;
    endtask

    task automatic go(input int ph);
        m_phase = ph;
        m_t     = 0;
    endtask

    // Advance the model by one frame using the inputs that were present at the edge.
    task automatic model_step();
        logic rise, er;
        if (!Reset) begin
            model_reset();
            return;
        end
        rise = fight_on && !m_prev_fight;
        er   = (keycode == 8'h28) && (m_prev_key != 8'h28);
        m_fight_req = 1'b0;
        m_run       = 1'b0;
        case (m_phase)
            P_IDLE: begin
                m_t++;
                if (rise) begin
                    m_species = 3'(m_lfsr[7:0] % NUM_SP);
`ifdef ENCOUNTER_SHINY_EN
                    m_shiny = (m_lfsr[11:8] == 4'h0);
`endif
                    m_accepted++;
                    if (m_count < 255) m_count++;
                    go(P_TRANS);
                end
            end
            P_TRANS: if (m_t == FLASH_FRAMES - 1) go(P_INTRO); else m_t++;
            P_INTRO: begin
                if (m_t == INTRO_FRAMES - 1) begin
                    m_sel = 1'b0;
                    go(P_MENU);
                end else m_t++;
            end
            P_MENU: begin
                m_t++;
                if (er) begin
                    if (!m_sel) begin
                        m_fight_req = 1'b1;
                        go(P_BATTLE);
                    end else begin
                        m_run = 1'b1;
                        go(P_COOL);
                    end
                end else if (keycode == 8'h1A) m_sel = 1'b0;
                else if (keycode == 8'h16) m_sel = 1'b1;
            end
            P_BATTLE: begin
                m_t++;
                if (battle_done) go(P_COOL);
            end
            default: if (m_t == COOLDOWN_FRAMES - 1) go(P_IDLE); else m_t++;
        endcase
        m_prev_fight = fight_on;
        m_prev_key   = keycode;
        m_lfsr       = lfsr_next(m_lfsr);
    endtask

    task automatic cycle();
        @(posedge frameClk);
        #1;
        model_step();
    endtask

    // Compare every DUT output against the model on each falling edge.
    initial begin
        forever begin
            @(negedge frameClk);
            check("overworld_lock", 16'(overworld_lock), 16'(m_phase != P_IDLE));
            check("battle_active", 16'(battle_active),
                  16'(m_phase == P_INTRO || m_phase == P_MENU || m_phase == P_BATTLE));
            check("flash_on", 16'(flash_on),
                  16'(m_phase == P_TRANS && ((m_t / FLASH_PERIOD) % 2) == 0));
            check("menu_sel", 16'(menu_sel), 16'(m_sel));
            check("fight_req", 16'(fight_req), 16'(m_fight_req));
            check("run_escape", 16'(run_escape), 16'(m_run));
            check("species", 16'(species), 16'(m_species));
            check("species_range", 16'(species < 3'(NUM_SP)), 16'd1);
            check("shiny", 16'(shiny), 16'(m_shiny));
            check("encounter_count", 16'(encounter_count), 16'(m_count));
        end
    end

    initial begin
        int cyc;
        int r;
        m_accepted = 0;
        model_reset();
        repeat (3) cycle();
        Reset = 1'b1;
        cycle();
        check("lfsr_model_pin", m_lfsr, 16'h59C3);
        check("post_reset_lock", 16'(overworld_lock), 16'd0);
        check("post_reset_count", 16'(encounter_count), 16'd0);

        // Encounter 1: fight path, Enter held across MENU entry, then a fresh press.
        fight_on = 1'b1;
        cycle();
        check("enc1_species", 16'(species), 16'd3);
        check("enc1_count", 16'(encounter_count), 16'd1);
        check("enc1_flash_start", 16'(flash_on), 16'd1);
        check("enc1_lock", 16'(overworld_lock), 16'd1);
        for (int k = 1; k <= 600; k++) begin
            keycode = ((k >= 85 && k <= 95) || k == 100) ? 8'h28 : 8'h00;
            cycle();
            if (k == 8)   check("flash_k8", 16'(flash_on), 16'd0);
            if (k == 16)  check("flash_k16", 16'(flash_on), 16'd1);
            if (k == 59) begin
                check("flash_k59", 16'(flash_on), 16'd0);
                check("active_k59", 16'(battle_active), 16'd0);
            end
            if (k == 60) check("active_k60", 16'(battle_active), 16'd1);
            if (k == 99)  check("fight_req_held_enter", 16'(fight_req), 16'd0);
            if (k == 100) check("fight_req_pulse", 16'(fight_req), 16'd1);
            if (k == 101) check("fight_req_one_cycle", 16'(fight_req), 16'd0);
            if (k == 600) begin
                check("stay_battle", 16'(battle_active), 16'd1);
                check("no_retrigger", 16'(encounter_count), 16'd1);
            end
        end
        battle_done = 1'b1;
        cycle();
        battle_done = 1'b0;
        repeat (125) cycle();
        check("back_to_idle", 16'(overworld_lock), 16'd0);
        fight_on = 1'b0;
        repeat (2) cycle();

        // Encounter 2: RUN path, edge during cooldown dropped, edge after idle accepted.
        fight_on = 1'b1;
        cycle();
        check("enc2_count", 16'(encounter_count), 16'd2);
        for (int k = 1; k <= 240; k++) begin
            keycode  = (k == 90 || k == 91) ? 8'h16 : (k == 95) ? 8'h28 : 8'h00;
            fight_on = (k < 140) || (k >= 150 && k < 160) || (k >= 220);
            cycle();
            if (k == 90) check("menu_sel_intro_ignored", 16'(menu_sel), 16'd0);
            if (k == 91) check("menu_sel_s", 16'(menu_sel), 16'd1);
            if (k == 94) check("run_before", 16'(run_escape), 16'd0);
            if (k == 95) begin
                check("run_pulse", 16'(run_escape), 16'd1);
                check("run_no_fight", 16'(fight_req), 16'd0);
            end
            if (k == 96) check("run_one_cycle", 16'(run_escape), 16'd0);
            if (k == 150) check("cooldown_drop", 16'(encounter_count), 16'd2);
            if (k == 214) check("cooldown_lock", 16'(overworld_lock), 16'd1);
            if (k == 215) check("cooldown_done", 16'(overworld_lock), 16'd0);
            if (k == 220) check("enc3_count", 16'(encounter_count), 16'd3);
            if (k == 240) begin
                check("pre_reset_flash", 16'(flash_on), 16'd1);
                check("pre_reset_lock", 16'(overworld_lock), 16'd1);
            end
        end

        // Asynchronous reset in the middle of the flash transition.
        Reset = 1'b0;
        model_reset();
        #1;
        check("async_flash", 16'(flash_on), 16'd0);
        check("async_lock", 16'(overworld_lock), 16'd0);
        check("async_active", 16'(battle_active), 16'd0);
        check("async_count", 16'(encounter_count), 16'd0);
        repeat (2) cycle();
        fight_on = 1'b0;
        keycode  = 8'h00;
        Reset    = 1'b1;
        repeat (3) cycle();

        // Randomized back-to-back encounters until at least 300 are accepted.
        m_accepted = 0;
        cyc = 0;
        while (m_accepted < 300 && cyc < 90000) begin
            fight_on = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 7));
            case (r)
                0, 1:    keycode = 8'h00;
                2:       keycode = 8'h1A;
                3:       keycode = 8'h16;
                4, 5:    keycode = 8'h28;
                6:       keycode = 8'($urandom);
                default: keycode = keycode;
            endcase
            battle_done = ($urandom_range(0, 7) == 0);
            cycle();
            cyc++;
        end
        check("random_encounters_reached", 16'(m_accepted >= 300), 16'd1);
        check("count_saturated", 16'(encounter_count), 16'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
